instr_encoder_writer: RTL and testbench
=======================================

# instr_encoder_writer

Byte-serial instruction encoder and memory writer: accepts one decoded instruction (group, opcode, register indices, immediates), packs it into the 16-bit (groups 1–4) or 32-bit (group 5) machine encoding understood by the group decoders, and streams it high byte first onto an 8-bit memory write port at an auto-incrementing address. It sits between the debug/loader front end and instruction memory, and serves as the bit-exact inverse of the group decoders for round-trip verification.

## Interface
Parameters:
- ADDR_WIDTH, 16, memory write address width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- addr_load  in  1  load write pointer from addr_in; honoured only in IDLE.
- addr_in  in  ADDR_WIDTH  new write pointer.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  high only in IDLE.
- group  in  instr_group  target group.
- opcode  in  6  opcode, LSB-aligned, truncated to group width (g1 3, g2 6, g3 2, g4 4, g5 3).
- ra_index, rb_index  in  4  register or pair number.
- rc_index  in  3  g3 rcp pair number.
- imm_a, imm_b  in  8  g1/g4 imm = imm_a; g5 i = imm_a, j = imm_b.
- mem_we  out  1  byte write strobe.
- mem_addr  out  ADDR_WIDTH  byte address.
- mem_data  out  8  byte data.
- done  out  1  one-cycle pulse with last byte.
- err  out  1  one-cycle pulse on unknown group.

## Operation
- States: IDLE, EMIT.
- IDLE: in_ready=1. If addr_load, pointer←addr_in. Handshake = in_valid & in_ready. If both addr_load and handshake occur in one cycle, the instruction starts at addr_in.
- On handshake with a known group: build a 32-bit shift register, left-aligned; bytes_left←2 (g1–g4) or 4 (g5); go to EMIT.
- Packing (MSB→LSB):
  - g1: 0, op[2:0], ra, imm_a.
  - g2: 10, op[5:0], ra, rb.
  - g3: 1100, op[1:0], ra, rb[2:0], rc.
  - g4: 1101, op[3:0], imm_a.
  - g5: 111000, op[2:0], ra, rb[2:0], imm_a, imm_b.
- Pair fields: where ig1/ig2/ig5 `*_is_for_pair(opcode)` is 1, the 4-bit field is {index[2:0],1'b0}, the inverse of the decoders' right shift. Otherwise the 4-bit index is used as-is. g3 and g5 rbp/rcp are always raw 3-bit pair numbers.
- Unknown group (instr_grp_unknown) on handshake: err=1 for one cycle, no writes, stay IDLE, pointer unchanged.
- EMIT, each cycle: mem_we=1, mem_data=shift[31:24], mem_addr=pointer; then shift<<=8, pointer+=1 (wraps 2^ADDR_WIDTH−1 → 0), bytes_left−=1. When bytes_left==1: done=1, next state IDLE.
- in_valid and addr_load are ignored while in EMIT.
- Reset (any cycle, including mid-EMIT): state IDLE, pointer 0, shift 0, bytes_left 0. All outputs 0 except in_ready=1. A partially written instruction is abandoned.

## Timing
- Handshake at edge N: bytes appear with mem_we at cycles N+1…N+2 (16-bit) or N+1…N+4 (32-bit). done coincides with the last byte. in_ready returns high the following cycle.
- Throughput: one 16-bit instruction per 3 cycles, one 32-bit instruction per 5 cycles.
- mem_we, mem_addr, mem_data and done are registered.
- err is registered and asserts in cycle N+1.
- mem_addr/mem_data are 0 whenever mem_we=0.

## Structure
- pkg_instr_dec gains the group ID prefix constants, per-group field widths, and a function `ig_encode(group, fields) → {len, word[31:0]}`. The decoders and this block share the existing `*_is_for_pair` functions.
- One sub-module: `instr_word_packer` (combinational packing). The FSM, pointer and shifter live in the top.

## Test plan
- g1, non-pair opcode 3, ra 5, imm_a 0x2A, addr_in 0x0100 → writes 0x35@0x0100, 0x2A@0x0101; done with 2nd byte.
- g2, non-pair opcode 0x05, ra 3, rb 9 → 0x85, 0x39. Repeat with a pair opcode, ra 2 → ra field 4; feed the result to the decoder and require ra_index 2.
- g3 op 2, ra 7, rbp 3, rcp 5 → 0xC9, 0xDD. g5 op 5, non-pair ra 2, rbp 6, imm 0x12/0x34, start 0xFFFE → 0xE2@FFFE, 0x96@FFFF, 0x12@0000, 0x34@0001.
- Unknown group → err pulse at N+1, mem_we never asserted, in_ready stays 1. Back-to-back valid g4 instructions → accepted every 3rd cycle, contiguous addresses.
- Reset asserted during the 2nd byte of g5 → outputs 0 asynchronously. After release, the next g1 instruction writes at 0x0000.
- Random round-trip: 1000 instructions of random known group → captured words, decoded by instr_group_decoder and the group decoders, reproduce all input fields (truncated per width).

Source files
------------

// File: rtl/instr_encoder_writer_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_writer_pkg
// Shared types and helpers for the instruction encoder/writer and the group
// decoders: group IDs, encoding prefixes, per-group opcode widths, the
// register-pair predicates and the word encoder ig_encode().
// -----------------------------------------------------------------------------
package instr_encoder_writer_pkg;

    typedef enum logic [2:0] {
        instr_grp_unknown = 3'd0,
        instr_grp_1       = 3'd1,
        instr_grp_2       = 3'd2,
        instr_grp_3       = 3'd3,
        instr_grp_4       = 3'd4,
        instr_grp_5       = 3'd5
    } instr_group;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } emit_state_t;

    // Group ID prefixes, placed at the MSB end of the encoded word.
    localparam logic [0:0] IG1_PREFIX = 1'b0;
    localparam logic [1:0] IG2_PREFIX = 2'b10;
    localparam logic [3:0] IG3_PREFIX = 4'b1100;
    localparam logic [3:0] IG4_PREFIX = 4'b1101;
    localparam logic [5:0] IG5_PREFIX = 6'b111000;

    // Opcode field widths per group.
    localparam int IG1_OP_W = 3;
    localparam int IG2_OP_W = 6;
    localparam int IG3_OP_W = 2;
    localparam int IG4_OP_W = 4;
    localparam int IG5_OP_W = 3;

    typedef struct packed {
        logic [5:0] opcode;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] rc;
        logic [7:0] imm_a;
        logic [7:0] imm_b;
    } instr_fields_t;

    typedef struct packed {
        logic        known;
        logic [2:0]  len;   // encoded length in bytes
        logic [31:0] word;  // left-aligned encoding
    } ig_enc_t;

    // Opcodes whose 4-bit register fields name a register pair; the decoders
    // shift such fields right by one.
    function automatic logic ig1_is_for_pair(input logic [2:0] op);
        return (op == 3'd7);
    endfunction

    function automatic logic ig2_is_for_pair(input logic [5:0] op);
        return (op[5:4] == 2'b11);
    endfunction

    function automatic logic ig5_is_for_pair(input logic [2:0] op);
        return (op[2:1] == 2'b11);
    endfunction

    // Pair number p is stored as register 2p so the decoder's shift recovers p.
    function automatic logic [3:0] pair_field(input logic is_pair, input logic [3:0] idx);
        return is_pair ? {idx[2:0], 1'b0} : idx;
    endfunction

    function automatic ig_enc_t ig_encode(input instr_group grp, input instr_fields_t f);
        ig_enc_t    r;
        logic       p;
        r = '0;
        p = 1'b0;
        case (grp)
            instr_grp_1: begin
                p      = ig1_is_for_pair(f.opcode[IG1_OP_W-1:0]);
                r.known = 1'b1;
                r.len   = 3'd2;
                r.word  = {IG1_PREFIX, f.opcode[IG1_OP_W-1:0], pair_field(p, f.ra),
                           f.imm_a, 16'h0000};
            end
            instr_grp_2: begin
                p      = ig2_is_for_pair(f.opcode[IG2_OP_W-1:0]);
                r.known = 1'b1;
                r.len   = 3'd2;
                r.word  = {IG2_PREFIX, f.opcode[IG2_OP_W-1:0], pair_field(p, f.ra),
                           pair_field(p, f.rb), 16'h0000};
            end
            instr_grp_3: begin
                r.known = 1'b1;
                r.len   = 3'd2;
                r.word  = {IG3_PREFIX, f.opcode[IG3_OP_W-1:0], f.ra, f.rb[2:0], f.rc,
                           16'h0000};
            end
            instr_grp_4: begin
                r.known = 1'b1;
                r.len   = 3'd2;
                r.word  = {IG4_PREFIX, f.opcode[IG4_OP_W-1:0], f.imm_a, 16'h0000};
            end
            instr_grp_5: begin
                p      = ig5_is_for_pair(f.opcode[IG5_OP_W-1:0]);
                r.known = 1'b1;
                r.len   = 3'd4;
                r.word  = {IG5_PREFIX, f.opcode[IG5_OP_W-1:0], pair_field(p, f.ra),
                           f.rb[2:0], f.imm_a, f.imm_b};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_encoder_writer_packer.sv
// -----------------------------------------------------------------------------
// instr_word_packer
// Combinational packing of one decoded instruction into its machine word.
//   group  : target instruction group
//   fields : opcode / register / immediate fields
//   known  : group is one of 1..5
//   len    : encoded length in bytes (2 or 4)
//   word   : left-aligned encoding, high byte in [31:24]
// -----------------------------------------------------------------------------
module instr_word_packer
    import instr_encoder_writer_pkg::*;
(
    input  instr_group    group,
    input  instr_fields_t fields,
    output logic          known,
    output logic [2:0]    len,
    output logic [31:0]   word
);

    ig_enc_t enc;

    assign enc   = ig_encode(group, fields);
    assign known = enc.known;
    assign len   = enc.len;
    assign word  = enc.word;

endmodule

// File: rtl/instr_encoder_writer.sv
// -----------------------------------------------------------------------------
// instr_encoder_writer
// Accepts one decoded instruction, packs it and streams it high byte first
// onto an 8-bit memory write port at an auto-incrementing address.
//   clk, reset          : clock, asynchronous active-high reset
//   addr_load, addr_in  : load write pointer (IDLE only)
//   in_valid, in_ready  : instruction handshake (in_ready high only in IDLE)
//   group, opcode, ra_index, rb_index, rc_index, imm_a, imm_b : fields
//   mem_we, mem_addr, mem_data : registered byte write port
//   done                : pulse with the last byte
//   err                 : pulse the cycle after an unknown-group handshake
// -----------------------------------------------------------------------------
module instr_encoder_writer
    import instr_encoder_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  addr_load,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  instr_group            group,
    input  logic [5:0]            opcode,
    input  logic [3:0]            ra_index,
    input  logic [3:0]            rb_index,
    input  logic [2:0]            rc_index,
    input  logic [7:0]            imm_a,
    input  logic [7:0]            imm_b,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_data,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    emit_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [31:0]           shift_q, shift_d;
    // Bytes still to be placed on the port after the one currently driven.
    logic [2:0]            bytes_left_q, bytes_left_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_data_q, mem_data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    instr_fields_t         fields;
    logic                  enc_known;
    logic [2:0]            enc_len;
    logic [31:0]           enc_word;
    logic                  handshake;
    logic [ADDR_WIDTH-1:0] start_ptr;

    assign fields = '{opcode: opcode, ra: ra_index, rb: rb_index, rc: rc_index,
                      imm_a: imm_a, imm_b: imm_b};

    instr_word_packer u_packer (
        .group  (group),
        .fields (fields),
        .known  (enc_known),
        .len    (enc_len),
        .word   (enc_word)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign handshake = in_valid & in_ready;
    // A same-cycle pointer load applies to the instruction being accepted.
    assign start_ptr = addr_load ? addr_in : ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            shift_q      <= '0;
            bytes_left_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            shift_q      <= shift_d;
            bytes_left_q <= bytes_left_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // EMIT spans exactly the cycles in which a byte is on the port, so the
    // state drops back to IDLE once the last registered byte has been shown.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (handshake && enc_known) state_d = ST_EMIT;
            ST_EMIT: if (bytes_left_q == 3'd0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The port is registered, so the first byte is loaded straight from the
    // packer on the accepting edge; later bytes come from the shifter.
    always_comb begin
        ptr_d        = ptr_q;
        shift_d      = shift_q;
        bytes_left_d = bytes_left_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_data_d   = '0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (addr_load) ptr_d = addr_in;
                if (handshake) begin
                    if (enc_known) begin
                        mem_we_d     = 1'b1;
                        mem_addr_d   = start_ptr;
                        mem_data_d   = enc_word[31:24];
                        shift_d      = {enc_word[23:0], 8'h00};
                        ptr_d        = start_ptr + ADDR_ONE;
                        bytes_left_d = enc_len - 3'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (bytes_left_q != 3'd0) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = ptr_q;
                    mem_data_d   = shift_q[31:24];
                    shift_d      = {shift_q[23:0], 8'h00};
                    ptr_d        = ptr_q + ADDR_ONE;
                    bytes_left_d = bytes_left_q - 3'd1;
                    done_d       = (bytes_left_q == 3'd1);
                end
            end
            default: ;
        endcase
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_instr_encoder_writer.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_writer
// Scoreboard bench: each accepted instruction pushes its expected start
// address, length and (optionally) word; the monitor collects the written
// bytes, checks addresses/done, decodes the word and compares the fields.
// -----------------------------------------------------------------------------
module tb_instr_encoder_writer;
    import instr_encoder_writer_pkg::*;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          addr_load = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    instr_group    group = instr_grp_unknown;
    logic [5:0]    opcode = '0;
    logic [3:0]    ra_index = '0;
    logic [3:0]    rb_index = '0;
    logic [2:0]    rc_index = '0;
    logic [7:0]    imm_a = '0;
    logic [7:0]    imm_b = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          done;
    logic          err;

    instr_encoder_writer #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .addr_load(addr_load), .addr_in(addr_in),
        .in_valid(in_valid), .in_ready(in_ready), .group(group), .opcode(opcode),
        .ra_index(ra_index), .rb_index(rb_index), .rc_index(rc_index),
        .imm_a(imm_a), .imm_b(imm_b), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data(mem_data), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        instr_group    g;
        instr_fields_t f;
    } dec_t;

    typedef struct {
        instr_group    grp;
        instr_fields_t f;
        logic          has_word;
        logic [31:0]   word;
        int            nbytes;
        logic [AW-1:0] addr;
    } sb_t;

    sb_t           sb_q[$];
    sb_t           mon_e;
    int            n_checks = 0;
    int            n_pass = 0;
    logic [AW-1:0] exp_ptr = '0;
    logic [31:0]   cap_w = '0;
    int            cap_n = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Inverse of the encoding, as the group decoders see it.
    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        d = '0;
        if (!w[31]) begin
            d.g = instr_grp_1;
            d.f.opcode = {3'b0, w[30:28]};
            d.f.ra = ig1_is_for_pair(w[30:28]) ? {1'b0, w[27:25]} : w[27:24];
            d.f.imm_a = w[23:16];
        end else if (w[31:30] == 2'b10) begin
            d.g = instr_grp_2;
            d.f.opcode = w[29:24];
            d.f.ra = ig2_is_for_pair(w[29:24]) ? {1'b0, w[23:21]} : w[23:20];
            d.f.rb = ig2_is_for_pair(w[29:24]) ? {1'b0, w[19:17]} : w[19:16];
        end else if (w[31:28] == 4'b1100) begin
            d.g = instr_grp_3;
            d.f.opcode = {4'b0, w[27:26]};
            d.f.ra = w[25:22];
            d.f.rb = {1'b0, w[21:19]};
            d.f.rc = w[18:16];
        end else if (w[31:28] == 4'b1101) begin
            d.g = instr_grp_4;
            d.f.opcode = {2'b0, w[27:24]};
            d.f.imm_a = w[23:16];
        end else if (w[31:26] == 6'b111000) begin
            d.g = instr_grp_5;
            d.f.opcode = {3'b0, w[25:23]};
            d.f.ra = ig5_is_for_pair(w[25:23]) ? {1'b0, w[22:20]} : w[22:19];
            d.f.rb = {1'b0, w[18:16]};
            d.f.imm_a = w[15:8];
            d.f.imm_b = w[7:0];
        end
        return d;
    endfunction

    // Fields the decoders can recover, after truncation to group widths.
    function automatic dec_t norm(input instr_group g, input instr_fields_t f);
        dec_t d;
        d = '0;
        d.g = g;
        case (g)
            instr_grp_1: begin
                d.f.opcode = {3'b0, f.opcode[2:0]};
                d.f.ra = ig1_is_for_pair(f.opcode[2:0]) ? {1'b0, f.ra[2:0]} : f.ra;
                d.f.imm_a = f.imm_a;
            end
            instr_grp_2: begin
                d.f.opcode = f.opcode;
                d.f.ra = ig2_is_for_pair(f.opcode) ? {1'b0, f.ra[2:0]} : f.ra;
                d.f.rb = ig2_is_for_pair(f.opcode) ? {1'b0, f.rb[2:0]} : f.rb;
            end
            instr_grp_3: begin
                d.f.opcode = {4'b0, f.opcode[1:0]};
                d.f.ra = f.ra;
                d.f.rb = {1'b0, f.rb[2:0]};
                d.f.rc = f.rc;
            end
            instr_grp_4: begin
                d.f.opcode = {2'b0, f.opcode[3:0]};
                d.f.imm_a = f.imm_a;
            end
            instr_grp_5: begin
                d.f.opcode = {3'b0, f.opcode[2:0]};
                d.f.ra = ig5_is_for_pair(f.opcode[2:0]) ? {1'b0, f.ra[2:0]} : f.ra;
                d.f.rb = {1'b0, f.rb[2:0]};
                d.f.imm_a = f.imm_a;
                d.f.imm_b = f.imm_b;
            end
            default: ;
        endcase
        return d;
    endfunction

    // Monitor: collect bytes, compare against the head of the scoreboard.
    always @(negedge clk) begin
        logic [AW-1:0] ea;
        logic [31:0]   full;
        if (reset) begin
            cap_n = 0;
        end else if (mem_we) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write", {mem_we, mem_addr, mem_data}, '0);
            end else begin
                mon_e = sb_q[0];
                ea = mon_e.addr + AW'(cap_n);
                chk("byte_addr", mem_addr, ea);
                chk("done_pos", done, (cap_n + 1 == mon_e.nbytes));
                cap_w = {cap_w[23:0], mem_data};
                cap_n++;
                if (cap_n == mon_e.nbytes) begin
                    full = (mon_e.nbytes == 2) ? {cap_w[15:0], 16'h0000} : cap_w;
                    if (mon_e.has_word) chk("word", full, mon_e.word);
                    chk("roundtrip", decode(full), norm(mon_e.grp, mon_e.f));
                    void'(sb_q.pop_front());
                    cap_n = 0;
                end
            end
        end else begin
            chk("idle_bus", {mem_addr, mem_data, done}, '0);
        end
    end

    // Drive one instruction at a negedge; returns at the negedge after the
    // accepting edge with in_valid dropped.
    task automatic send(input instr_group g, input instr_fields_t f, input logic ld,
                        input logic [AW-1:0] a, input logic hw, input logic [31:0] w,
                        output time hs_t);
        int            guard;
        sb_t           e;
        logic          known;
        logic [AW-1:0] start;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("ready_timeout", in_ready, 1);
        group = g; opcode = f.opcode; ra_index = f.ra; rb_index = f.rb;
        rc_index = f.rc; imm_a = f.imm_a; imm_b = f.imm_b;
        addr_load = ld; addr_in = a; in_valid = 1'b1;
        known = (g >= instr_grp_1) && (g <= instr_grp_5);
        start = ld ? a : exp_ptr;
        exp_ptr = start;
        if (known) begin
            e.grp = g; e.f = f; e.has_word = hw; e.word = w;
            e.nbytes = (g == instr_grp_5) ? 4 : 2;
            e.addr = start;
            sb_q.push_back(e);
            exp_ptr = start + AW'(e.nbytes);
        end
        @(posedge clk);
        hs_t = $time;
        @(negedge clk);
        in_valid = 1'b0;
        addr_load = 1'b0;
        if (known) begin
            chk("first_byte_latency", mem_we, 1);
            chk("busy_not_ready", in_ready, 0);
            chk("no_err", err, 0);
        end else begin
            chk("err_pulse", err, 1);
            chk("err_no_write", mem_we, 0);
            chk("err_ready", in_ready, 1);
        end
    endtask

    function automatic instr_fields_t mk(input logic [5:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [2:0] rc,
                                         input logic [7:0] ia, input logic [7:0] ib);
        instr_fields_t f;
        f = '{opcode: op, ra: ra, rb: rb, rc: rc, imm_a: ia, imm_b: ib};
        return f;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0, t1, t2;
        int  guard;
        instr_fields_t f;
        instr_group    g;

        repeat (2) @(negedge clk);
        chk("reset_outputs", {in_ready, mem_we, mem_addr, mem_data, done, err},
            {1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0});
        reset = 1'b0;
        @(negedge clk);

        send(instr_grp_1, mk(6'd3, 4'd5, 4'd0, 3'd0, 8'h2A, 8'h00), 1'b1, 16'h0100,
             1'b1, 32'h352A0000, t0);
        send(instr_grp_2, mk(6'h05, 4'd3, 4'd9, 3'd0, 8'h00, 8'h00), 1'b0, '0,
             1'b1, 32'h85390000, t0);
        send(instr_grp_2, mk(6'h30, 4'd2, 4'd9, 3'd0, 8'h00, 8'h00), 1'b0, '0,
             1'b1, 32'hB0420000, t0);
        send(instr_grp_3, mk(6'd2, 4'd7, 4'd3, 3'd5, 8'h00, 8'h00), 1'b0, '0,
             1'b1, 32'hC9DD0000, t0);
        send(instr_grp_5, mk(6'd5, 4'd2, 4'd6, 3'd0, 8'h12, 8'h34), 1'b1, 16'hFFFE,
             1'b1, 32'hE2961234, t0);

        // Unknown group: error pulse only, pointer untouched.
        send(instr_grp_unknown, mk(6'd1, 4'd1, 4'd1, 3'd1, 8'h11, 8'h22), 1'b0, '0,
             1'b0, 32'h0, t0);
        @(negedge clk);
        chk("err_one_cycle", err, 0);
        chk("err_stays_ready", in_ready, 1);

        // Back-to-back group 4 at contiguous addresses.
        send(instr_grp_4, mk(6'h0A, 4'd0, 4'd0, 3'd0, 8'h01, 8'h00), 1'b1, 16'h0200,
             1'b1, 32'hDA010000, t0);
        send(instr_grp_4, mk(6'h0A, 4'd0, 4'd0, 3'd0, 8'h02, 8'h00), 1'b0, '0,
             1'b1, 32'hDA020000, t1);
        send(instr_grp_4, mk(6'h03, 4'd0, 4'd0, 3'd0, 8'h03, 8'h00), 1'b0, '0,
             1'b1, 32'hD3030000, t2);
        chk("b2b_spacing_1", t1 - t0, 30);
        chk("b2b_spacing_2", t2 - t1, 30);

        // Reset during the second byte of a group 5 write.
        send(instr_grp_5, mk(6'd1, 4'd4, 4'd1, 3'd0, 8'hAA, 8'hBB), 1'b0, '0,
             1'b1, 32'hE0A1AABB, t0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", {in_ready, mem_we, mem_addr, mem_data, done, err},
            {1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0});
        @(negedge clk);
        sb_q.delete();
        exp_ptr = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(instr_grp_1, mk(6'd7, 4'd3, 4'd0, 3'd0, 8'h5A, 8'h00), 1'b0, '0,
             1'b1, 32'h765A0000, t0);
        chk("post_reset_addr", mem_addr, 0);

        // Random round-trip.
        for (int i = 0; i < 1000; i++) begin
            g = instr_group'(3'($urandom_range(1, 5)));
            f = mk(6'($urandom), 4'($urandom), 4'($urandom), 3'($urandom),
                   8'($urandom), 8'($urandom));
            send(g, f, ($urandom_range(0, 7) == 0), AW'($urandom), 1'b0, 32'h0, t0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        guard = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
